// File: rtl/adder_tree_accum.sv
// rtl/adder_tree_accum.sv - pipelined unsigned adder tree with optional windowed accumulator
module adder_tree_accum #(
    parameter int NUM_OF_INS      = 5,
    parameter int WIDTH_PER_IN    = 16,
    parameter int ACC_BEATS       = 4,
    parameter int WIDTH_FINAL_OUT = 21,
    parameter int SATURATE        = 1
) (
    input  logic                               i_Clk,
    input  logic                               i_Reset,
    input  logic [NUM_OF_INS*WIDTH_PER_IN-1:0] i_In_All,
    input  logic                               i_Data_Valid_In,
    input  logic                               i_Acc_Mode,
    input  logic                               i_Acc_Clear,
    output logic [WIDTH_FINAL_OUT-1:0]         o_Out_All,
    output logic                               o_Data_Valid_Out,
    output logic                               o_Overflow,
    output logic                               o_Busy
);

    localparam int N      = NUM_OF_INS;
    localparam int W      = WIDTH_PER_IN;
    localparam int WF     = WIDTH_FINAL_OUT;
    localparam int WE     = WF + 1;
    localparam int LAYERS = $clog2(N);
    localparam int TW     = W + LAYERS;
    localparam int CW     = $clog2(ACC_BEATS + 1);

    // Operand count of layer l, and bit offset of layer l inside the flat operand bus.
    function automatic int lane_cnt(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    function automatic int bus_off(input int l);
        int o;
        o = 0;
        for (int j = 0; j < l; j++) begin
            o += lane_cnt(j) * (W + j);
        end
        return o;
    endfunction

    localparam int BUS_W = bus_off(LAYERS + 1);

    if (WF < TW) begin : g_width_check
        $error("WIDTH_FINAL_OUT too small for NUM_OF_INS lanes of WIDTH_PER_IN bits");
    end

    logic [BUS_W-1:0] bus;
    logic [LAYERS:0]  vld;

    assign bus[N*W-1:0] = i_In_All;
    assign vld[0]       = i_Data_Valid_In;

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int NI = lane_cnt(l);
        localparam int NO = lane_cnt(l + 1);
        localparam int WI = W + l;
        localparam int WO = WI + 1;
        localparam int OI = bus_off(l);
        localparam int OO = bus_off(l + 1);

        logic [NO*WO-1:0] sum_d;
        logic [NO*WO-1:0] sum_q;
        logic             vld_q;

        for (genvar k = 0; k < NO; k++) begin : g_node
            if (2 * k + 1 < NI) begin : g_pair
                assign sum_d[k*WO +: WO] = WO'(bus[OI + 2*k*WI +: WI])
                                         + WO'(bus[OI + (2*k+1)*WI +: WI]);
            end else begin : g_pass
                assign sum_d[k*WO +: WO] = WO'(bus[OI + 2*k*WI +: WI]);
            end
        end

        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                sum_q <= '0;
                vld_q <= 1'b0;
            end else begin
                sum_q <= sum_d;
                vld_q <= vld[l];
            end
        end

        assign bus[OO +: NO*WO] = sum_q;
        assign vld[l+1]         = vld_q;
    end

    logic [TW-1:0] tree_sum;
    logic          tree_vld;
    logic          stage_busy;

    assign tree_sum = bus[BUS_W-1 -: TW];
    assign tree_vld = vld[LAYERS];

    if (LAYERS > 0) begin : g_busy
        assign stage_busy = |vld[LAYERS:1];
    end else begin : g_no_busy
        assign stage_busy = 1'b0;
    end

    logic [WF-1:0] acc_q, acc_d, acc_base, acc_next;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic          ovf_q, ovf_d, ovf_base;
    logic [WF-1:0] out_q, out_d;
    logic          ovfo_q, ovfo_d;
    logic          strobe_q, strobe_d;
    logic          mode_q;
    logic          win_clear;
    logic [WE-1:0] sum_ext;

    // A mode change restarts the window exactly like an explicit clear.
    always_comb begin
        win_clear = i_Acc_Clear | (i_Acc_Mode != mode_q);
        acc_base  = win_clear ? '0 : acc_q;
        cnt_base  = win_clear ? '0 : cnt_q;
        ovf_base  = win_clear ? 1'b0 : ovf_q;
        sum_ext   = {1'b0, acc_base} + WE'(tree_sum);
        acc_next  = (sum_ext[WF] && SATURATE != 0) ? '1 : sum_ext[WF-1:0];

        acc_d    = acc_base;
        cnt_d    = cnt_base;
        ovf_d    = ovf_base;
        out_d    = out_q;
        ovfo_d   = ovfo_q;
        strobe_d = 1'b0;

        if (tree_vld) begin
            if (!i_Acc_Mode) begin
                out_d    = WF'(tree_sum);
                ovfo_d   = 1'b0;
                strobe_d = 1'b1;
            end else if (cnt_base == CW'(ACC_BEATS - 1)) begin
                out_d    = acc_next;
                ovfo_d   = ovf_base | sum_ext[WF];
                strobe_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_base + CW'(1);
                ovf_d = ovf_base | sum_ext[WF];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            out_q    <= '0;
            ovfo_q   <= 1'b0;
            strobe_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
            ovfo_q   <= ovfo_d;
            strobe_q <= strobe_d;
            mode_q   <= i_Acc_Mode;
        end
    end

    assign o_Out_All        = out_q;
    assign o_Data_Valid_Out = strobe_q;
    assign o_Overflow       = ovfo_q;
    assign o_Busy           = stage_busy | (cnt_q != '0);

endmodule

// File: tb/tb_adder_tree_accum.sv
// tb/tb_adder_tree_accum.sv - bench for adder_tree_accum across three width/saturation variants
module tb_adder_tree_accum;

    localparam int N   = 5;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   in_all = '0;
    logic             vin = 1'b0, mode = 1'b0, clr = 1'b0;
    logic [20:0]      out0;
    logic [19:0]      out1, out2;
    logic             v0, v1, v2, f0, f1, f2, b0, b1, b2;

    adder_tree_accum #(.NUM_OF_INS(N), .WIDTH_PER_IN(W), .ACC_BEATS(4), .WIDTH_FINAL_OUT(21), .SATURATE(1)) dut0 (
        .i_Clk(clk), .i_Reset(rst), .i_In_All(in_all), .i_Data_Valid_In(vin), .i_Acc_Mode(mode),
        .i_Acc_Clear(clr), .o_Out_All(out0), .o_Data_Valid_Out(v0), .o_Overflow(f0), .o_Busy(b0));
    adder_tree_accum #(.NUM_OF_INS(N), .WIDTH_PER_IN(W), .ACC_BEATS(4), .WIDTH_FINAL_OUT(20), .SATURATE(1)) dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_In_All(in_all), .i_Data_Valid_In(vin), .i_Acc_Mode(mode),
        .i_Acc_Clear(clr), .o_Out_All(out1), .o_Data_Valid_Out(v1), .o_Overflow(f1), .o_Busy(b1));
    adder_tree_accum #(.NUM_OF_INS(N), .WIDTH_PER_IN(W), .ACC_BEATS(4), .WIDTH_FINAL_OUT(20), .SATURATE(0)) dut2 (
        .i_Clk(clk), .i_Reset(rst), .i_In_All(in_all), .i_Data_Valid_In(vin), .i_Acc_Mode(mode),
        .i_Acc_Clear(clr), .o_Out_All(out2), .o_Data_Valid_Out(v2), .o_Overflow(f2), .o_Busy(b2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        int          cyc;
        logic [20:0] val;
        logic        ovf;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    longint m_sum = 0;
    int     m_cnt = 0;

    always @(negedge clk) begin
        if (v0) obs.push_back(ev_t'{0, cyc, out0, f0});
        if (v1) obs.push_back(ev_t'{1, cyc, {1'b0, out1}, f1});
        if (v2) obs.push_back(ev_t'{2, cyc, {1'b0, out2}, f2});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [N*W-1:0] lanes(input logic [W-1:0] x);
        return {N{x}};
    endfunction

    // Window model: exact integer sum of the window, then clamp or wrap per variant.
    task automatic model_beat(input longint s);
        int     c;
        longint max21, max20;
        c     = cyc + LAT;
        max21 = 64'd2097151;
        max20 = 64'd1048575;
        if (!mode) begin
            for (int d = 0; d < 3; d++) exp_q.push_back(ev_t'{d, c, 21'(s), 1'b0});
        end else begin
            m_sum += s;
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back(ev_t'{0, c, (m_sum > max21) ? 21'h1FFFFF : 21'(m_sum), m_sum > max21});
                exp_q.push_back(ev_t'{1, c, (m_sum > max20) ? 21'h0FFFFF : 21'(m_sum), m_sum > max20});
                exp_q.push_back(ev_t'{2, c, 21'(m_sum % 64'd1048576), m_sum > max20});
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic beat(input logic [N*W-1:0] v);
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(v[k*W +: W]);
        in_all = v;
        vin    = 1'b1;
        model_beat(s);
        step();
        vin = 1'b0;
    endtask

    task automatic set_mode(input logic m);
        mode = m;
        clr  = 1'b1;
        step();
        clr   = 1'b0;
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_cmp++;
        if ({out0, v0, f0, b0} !== 24'd0) begin
            n_bad++; $display("FAIL reset_dut0: got out=%h v=%b ovf=%b busy=%b, want all 0", out0, v0, f0, b0);
        end
        n_cmp++;
        if ({out1, v1, f1, b1, out2, v2, f2, b2} !== 46'd0) begin
            n_bad++; $display("FAIL reset_dut12: got %h/%b%b%b %h/%b%b%b, want all 0", out1, v1, f1, b1, out2, v2, f2, b2);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int t;
        set_mode(1'b0);
        t = cyc;
        beat(lanes(16'hFFFF));
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_bad++; $display("FAIL single_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].id !== exp_q[i].id || obs[i].cyc !== exp_q[i].cyc || obs[i].val !== exp_q[i].val || obs[i].ovf !== exp_q[i].ovf) begin
                n_bad++; $display("FAIL single_ev%0d: got id%0d c%0d %h o%b want id%0d c%0d %h o%b", i,
                    obs[i].id, obs[i].cyc, obs[i].val, obs[i].ovf, exp_q[i].id, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
            end
        end
        n_cmp++;
        if (obs.size() < 1 || obs[0].val !== 21'h4FFFB || obs[0].cyc !== t + 4) begin
            n_bad++; $display("FAIL single_latency: got n=%0d, want 0x4FFFB at cycle %0d", obs.size(), t + 4);
        end
        n_cmp++;
        if (out0 !== 21'h4FFFB || v0 !== 1'b0) begin
            n_bad++; $display("FAIL single_hold: got out=%h v=%b want 4fffb/0", out0, v0);
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 10; k++) beat(lanes(16'(k)));
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_bad++; $display("FAIL stream_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].id !== exp_q[i].id || obs[i].cyc !== exp_q[i].cyc || obs[i].val !== exp_q[i].val || obs[i].ovf !== exp_q[i].ovf) begin
                n_bad++; $display("FAIL stream_ev%0d: got id%0d c%0d %h o%b want id%0d c%0d %h o%b", i,
                    obs[i].id, obs[i].cyc, obs[i].val, obs[i].ovf, exp_q[i].id, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
            end
        end
        n_cmp++;
        if (out0 !== 21'd50) begin
            n_bad++; $display("FAIL stream_last: got %0d want 50", out0);
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_accum_bubbles();
        int t0;
        set_mode(1'b1);
        t0 = cyc;
        beat(lanes(16'd1)); idle(1);
        beat(lanes(16'd1)); idle(2);
        beat(lanes(16'd1)); idle(3);
        beat(lanes(16'd1));
        n_cmp++;
        if (b0 !== 1'b1) begin
            n_bad++; $display("FAIL accum_busy: got %b want 1", b0);
        end
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != 3 || obs[0].cyc !== t0 + 13 || obs[0].val !== 21'd20) begin
            n_bad++; $display("FAIL accum_bubbles: got n=%0d, want 3 strobes of 20 at cycle %0d", obs.size(), t0 + 13);
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].id !== exp_q[i].id || obs[i].cyc !== exp_q[i].cyc || obs[i].val !== exp_q[i].val || obs[i].ovf !== exp_q[i].ovf) begin
                n_bad++; $display("FAIL accum_ev%0d: got id%0d c%0d %h o%b want id%0d c%0d %h o%b", i,
                    obs[i].id, obs[i].cyc, obs[i].val, obs[i].ovf, exp_q[i].id, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
            end
        end
        n_cmp++;
        if (b0 !== 1'b0) begin
            n_bad++; $display("FAIL accum_idle_busy: got %b want 0", b0);
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) beat(lanes(16'hFFFF));
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != 3 || obs[0].val !== 21'h13FFEC || obs[0].ovf !== 1'b0) begin
            n_bad++; $display("FAIL sat_wide: got n=%0d val=%h ovf=%b want 13ffec/0", obs.size(), obs[0].val, obs[0].ovf);
        end
        n_cmp++;
        if (obs.size() != 3 || obs[1].val !== 21'h0FFFFF || obs[1].ovf !== 1'b1) begin
            n_bad++; $display("FAIL sat_clamp: got val=%h ovf=%b want fffff/1", obs[1].val, obs[1].ovf);
        end
        n_cmp++;
        if (obs.size() != 3 || obs[2].val !== 21'h03FFEC || obs[2].ovf !== 1'b1) begin
            n_bad++; $display("FAIL sat_wrap: got val=%h ovf=%b want 3ffec/1", obs[2].val, obs[2].ovf);
        end
        n_cmp++;
        if (f1 !== 1'b1 || f2 !== 1'b1 || out1 !== 20'hFFFFF) begin
            n_bad++; $display("FAIL sat_hold: got f1=%b f2=%b out1=%h want 1/1/fffff", f1, f2, out1);
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_clear();
        beat(lanes(16'd7));
        beat(lanes(16'd7));
        idle(LAT + 2);
        clr = 1'b1;
        m_sum = 0;
        m_cnt = 0;
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) beat(lanes(16'd1));
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != 3 || obs[0].val !== 21'd20 || obs[1].ovf !== 1'b0) begin
            n_bad++; $display("FAIL clear_window: got n=%0d val=%0d want 3 strobes of 20", obs.size(), obs[0].val);
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        set_mode(1'b0);
        for (int i = 0; i < 24; i++) begin
            beat({$urandom(), $urandom(), $urandom()});
            idle($urandom_range(0, 2));
        end
        idle(LAT + 1);
        set_mode(1'b1);
        for (int i = 0; i < 32; i++) begin
            beat({$urandom(), $urandom(), $urandom()});
            idle($urandom_range(0, 2));
        end
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_bad++; $display("FAIL random_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].id !== exp_q[i].id || obs[i].cyc !== exp_q[i].cyc || obs[i].val !== exp_q[i].val || obs[i].ovf !== exp_q[i].ovf) begin
                n_bad++; $display("FAIL random_ev%0d: got id%0d c%0d %h o%b want id%0d c%0d %h o%b", i,
                    obs[i].id, obs[i].cyc, obs[i].val, obs[i].ovf, exp_q[i].id, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        set_mode(1'b0);
        in_all = lanes(16'd3);
        vin = 1'b1;
        step();
        in_all = lanes(16'd4);
        step();
        vin = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (out0 !== 21'd0 || v0 !== 1'b0 || b0 !== 1'b0) begin
            n_bad++; $display("FAIL inflight_reset: got out=%h v=%b busy=%b want 0/0/0", out0, v0, b0);
        end
        idle(LAT + 2);
        n_cmp++;
        if (obs.size() != 0) begin
            n_bad++; $display("FAIL inflight_dropped: got %0d strobes want 0", obs.size());
        end
        obs.delete();
        beat(lanes(16'd9));
        idle(LAT + 3);
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_bad++; $display("FAIL inflight_fresh_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].id !== exp_q[i].id || obs[i].cyc !== exp_q[i].cyc || obs[i].val !== exp_q[i].val || obs[i].ovf !== exp_q[i].ovf) begin
                n_bad++; $display("FAIL inflight_ev%0d: got id%0d c%0d %h o%b want id%0d c%0d %h o%b", i,
                    obs[i].id, obs[i].cyc, obs[i].val, obs[i].ovf, exp_q[i].id, exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_accum_bubbles();
        test_saturate();
        test_clear();
        test_random();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
